// File: rtl/acq_fifo_sequencer.sv
// Acquisition run sequencer for the two-channel processing datapath.
// It pulses reset_op into the datapath and then accepts N 64-bit results per channel.
// Each result is split into an up word [63:32] and a down word [31:0].
// The two words are streamed into that channel's up/down Avalon-ST FIFOs.
// Each half completes on its own, so one stalled FIFO never drops or reorders data.
module acq_fifo_sequencer #(
    parameter int CLR_CYC = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] n_samples_i,
    input  logic             ch0_valid_i,
    input  logic [63:0]      ch0_data_i,
    output logic             ch0_ready_o,
    input  logic             ch1_valid_i,
    input  logic [63:0]      ch1_data_i,
    output logic             ch1_ready_o,
    output logic             fifo0_up_valid_o,
    output logic [31:0]      fifo0_up_data_o,
    input  logic             fifo0_up_ready_i,
    output logic             fifo0_dn_valid_o,
    output logic [31:0]      fifo0_dn_data_o,
    input  logic             fifo0_dn_ready_i,
    output logic             fifo1_up_valid_o,
    output logic [31:0]      fifo1_up_data_o,
    input  logic             fifo1_up_ready_i,
    output logic             fifo1_dn_valid_o,
    output logic [31:0]      fifo1_dn_data_o,
    input  logic             fifo1_dn_ready_i,
    output logic             reset_op_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count0_o,
    output logic [CNT_W-1:0] count1_o
);

    localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             start_q;
    logic             start_edge;
    logic             run_start;
    logic             abort_flush;
    logic             all_done;

    // Per-channel views so that both writers come from one generate body
    logic [1:0]             ch_valid;
    logic [1:0][63:0]       ch_data;
    logic [1:0]             up_ready;
    logic [1:0]             dn_ready;
    logic [1:0]             ch_ready;
    logic [1:0]             up_pend;
    logic [1:0]             dn_pend;
    logic [1:0][63:0]       hold;
    logic [1:0][CNT_W-1:0]  count;

    assign ch_valid = {ch1_valid_i, ch0_valid_i};
    assign ch_data  = {ch1_data_i, ch0_data_i};
    assign up_ready = {fifo1_up_ready_i, fifo0_up_ready_i};
    assign dn_ready = {fifo1_dn_ready_i, fifo0_dn_ready_i};

    assign start_edge  = start_i & ~start_q;
    assign abort_flush = abort_i & (state_q != ST_IDLE);
    assign all_done    = (count[0] == n_q) & (count[1] == n_q) & ~(|up_pend) & ~(|dn_pend);

    // State, clear-phase counter, latched N and start history
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            n_q       <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            n_q       <= n_d;
            start_q   <= start_i;
        end
    end

    // Next-state logic; abort overrides every transition out of a non-idle state
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        n_d       = n_q;
        run_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge && !abort_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    n_d       = n_samples_i;
                    run_start = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (all_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_flush) begin
            state_d = ST_IDLE;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [63:0]      hold_q, hold_d;
        logic             up_pend_q, up_pend_d;
        logic             dn_pend_q, dn_pend_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic             up_fire;
        logic             dn_fire;
        logic             ready;
        logic             accept;

        assign up_fire = up_pend_q & up_ready[gi];
        assign dn_fire = dn_pend_q & dn_ready[gi];
        // Abort masks ready so that a result is never taken on the cycle the run is dropped
        assign ready   = (state_q == ST_RUN) & ~abort_i & (count_q < n_q)
                       & (~up_pend_q | up_fire) & (~dn_pend_q | dn_fire);
        assign accept  = ch_valid[gi] & ready;

        // Holding register, half-pending flags and result counter
        always_comb begin
            hold_d    = hold_q;
            up_pend_d = up_pend_q;
            dn_pend_d = dn_pend_q;
            count_d   = count_q;
            if (run_start) begin
                count_d = '0;
            end
            if (abort_flush) begin
                up_pend_d = 1'b0;
                dn_pend_d = 1'b0;
            end else begin
                if (up_fire) begin
                    up_pend_d = 1'b0;
                end
                if (dn_fire) begin
                    dn_pend_d = 1'b0;
                end
                if (accept) begin
                    hold_d    = ch_data[gi];
                    up_pend_d = 1'b1;
                    dn_pend_d = 1'b1;
                    count_d   = count_q + 1'b1;
                end
            end
        end

        // Channel writer registers
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                hold_q    <= '0;
                up_pend_q <= 1'b0;
                dn_pend_q <= 1'b0;
                count_q   <= '0;
            end else begin
                hold_q    <= hold_d;
                up_pend_q <= up_pend_d;
                dn_pend_q <= dn_pend_d;
                count_q   <= count_d;
            end
        end

        assign hold[gi]     = hold_q;
        assign up_pend[gi]  = up_pend_q;
        assign dn_pend[gi]  = dn_pend_q;
        assign count[gi]    = count_q;
        assign ch_ready[gi] = ready;
    end

    assign ch0_ready_o      = ch_ready[0];
    assign ch1_ready_o      = ch_ready[1];
    assign fifo0_up_valid_o = up_pend[0];
    assign fifo0_up_data_o  = hold[0][63:32];
    assign fifo0_dn_valid_o = dn_pend[0];
    assign fifo0_dn_data_o  = hold[0][31:0];
    assign fifo1_up_valid_o = up_pend[1];
    assign fifo1_up_data_o  = hold[1][63:32];
    assign fifo1_dn_valid_o = dn_pend[1];
    assign fifo1_dn_data_o  = hold[1][31:0];
    assign reset_op_o       = (state_q == ST_CLEAR);
    assign busy_o           = (state_q == ST_CLEAR) | (state_q == ST_RUN);
    assign done_o           = (state_q == ST_DONE);
    assign count0_o         = count[0];
    assign count1_o         = count[1];

endmodule

// File: tb/tb_acq_fifo_sequencer.sv
// Bench for acq_fifo_sequencer: directed scenarios plus randomized runs, every cycle
// compared against a word-queue reference model of the sequencer.
module tb_acq_fifo_sequencer;

    localparam int CLR_CYC = 4;
    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] n_samples;
    logic        ch_valid [2];
    logic [63:0] ch_data  [2];
    logic        up_rdy   [2];
    logic        dn_rdy   [2];
    logic        ch_ready [2];
    logic        up_valid [2];
    logic [31:0] up_data  [2];
    logic        dn_valid [2];
    logic [31:0] dn_data  [2];
    logic        reset_op;
    logic        busy;
    logic        done;
    logic [31:0] count0;
    logic [31:0] count1;

    int checks = 0;
    int errors = 0;

    // reference model: run phase, latched N, per-channel counts, outstanding words
    int          m_phase;
    int          m_clr;
    logic [31:0] m_n;
    logic [31:0] m_cnt [2];
    logic [31:0] m_upq [2][$];
    logic [31:0] m_dnq [2][$];
    logic        m_start_prev;

    // observation counters used by directed scenarios
    int clr_seen;
    int rdy_seen;
    int run_seen;
    int runs;
    logic prev_rop;

    always #5 clk = ~clk;

    acq_fifo_sequencer #(.CLR_CYC(CLR_CYC), .CNT_W(32)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_i          (start),
        .abort_i          (abort),
        .n_samples_i      (n_samples),
        .ch0_valid_i      (ch_valid[0]),
        .ch0_data_i       (ch_data[0]),
        .ch0_ready_o      (ch_ready[0]),
        .ch1_valid_i      (ch_valid[1]),
        .ch1_data_i       (ch_data[1]),
        .ch1_ready_o      (ch_ready[1]),
        .fifo0_up_valid_o (up_valid[0]),
        .fifo0_up_data_o  (up_data[0]),
        .fifo0_up_ready_i (up_rdy[0]),
        .fifo0_dn_valid_o (dn_valid[0]),
        .fifo0_dn_data_o  (dn_data[0]),
        .fifo0_dn_ready_i (dn_rdy[0]),
        .fifo1_up_valid_o (up_valid[1]),
        .fifo1_up_data_o  (up_data[1]),
        .fifo1_up_ready_i (up_rdy[1]),
        .fifo1_dn_valid_o (dn_valid[1]),
        .fifo1_dn_data_o  (dn_data[1]),
        .fifo1_dn_ready_i (dn_rdy[1]),
        .reset_op_o       (reset_op),
        .busy_o           (busy),
        .done_o           (done),
        .count0_o         (count0),
        .count1_o         (count1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase      = P_IDLE;
        m_clr        = 0;
        m_n          = '0;
        m_start_prev = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = '0;
            m_upq[c].delete();
            m_dnq[c].delete();
        end
    endtask

    function automatic logic exp_ready(input int c);
        return (m_phase == P_RUN) && !abort && (m_cnt[c] < m_n)
            && (m_upq[c].size() == 0 || up_rdy[c]) && (m_dnq[c].size() == 0 || dn_rdy[c]);
    endfunction

    task automatic check_outputs();
        logic [31:0] cnt_obs [2];
        cnt_obs[0] = count0;
        cnt_obs[1] = count1;
        chk("reset_op", 64'(reset_op), 64'(m_phase == P_CLEAR));
        chk("busy", 64'(busy), 64'(m_phase == P_CLEAR || m_phase == P_RUN));
        chk("done", 64'(done), 64'(m_phase == P_DONE));
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("count%0d", c), 64'(cnt_obs[c]), 64'(m_cnt[c]));
            chk($sformatf("ch%0d_ready", c), 64'(ch_ready[c]), 64'(exp_ready(c)));
            chk($sformatf("up%0d_valid", c), 64'(up_valid[c]), 64'(m_upq[c].size() != 0));
            chk($sformatf("dn%0d_valid", c), 64'(dn_valid[c]), 64'(m_dnq[c].size() != 0));
            if (m_upq[c].size() != 0) chk($sformatf("up%0d_data", c), 64'(up_data[c]), 64'(m_upq[c][0]));
            if (m_dnq[c].size() != 0) chk($sformatf("dn%0d_data", c), 64'(dn_data[c]), 64'(m_dnq[c][0]));
        end
    endtask

    // advance the model across one rising edge using the inputs currently applied
    task automatic model_next();
        logic start_edge;
        logic fin;
        logic acc  [2];
        logic upf  [2];
        logic dnf  [2];
        start_edge = start && !m_start_prev;
        fin = (m_cnt[0] == m_n) && (m_cnt[1] == m_n);
        for (int c = 0; c < 2; c++) begin
            acc[c] = ch_valid[c] && exp_ready(c);
            upf[c] = (m_upq[c].size() != 0) && up_rdy[c];
            dnf[c] = (m_dnq[c].size() != 0) && dn_rdy[c];
            if (m_upq[c].size() != 0 || m_dnq[c].size() != 0) fin = 1'b0;
        end
        if (abort && m_phase != P_IDLE) begin
            for (int c = 0; c < 2; c++) begin
                m_upq[c].delete();
                m_dnq[c].delete();
            end
            m_phase = P_IDLE;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (upf[c]) void'(m_upq[c].pop_front());
                if (dnf[c]) void'(m_dnq[c].pop_front());
                if (acc[c]) begin
                    m_upq[c].push_back(ch_data[c][63:32]);
                    m_dnq[c].push_back(ch_data[c][31:0]);
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            case (m_phase)
                P_IDLE: if (start_edge && !abort) begin
                    m_phase  = P_CLEAR;
                    m_clr    = CLR_CYC;
                    m_n      = n_samples;
                    m_cnt[0] = '0;
                    m_cnt[1] = '0;
                end
                P_CLEAR: begin
                    m_clr--;
                    if (m_clr == 0) m_phase = P_RUN;
                end
                P_RUN:  if (fin) m_phase = P_DONE;
                P_DONE: if (!start) m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
        end
        m_start_prev = start;
    endtask

    // one clock: sample away from the edge, compare, predict, advance to next falling edge
    task automatic step();
        #1;
        check_outputs();
        if (reset_op === 1'b1) clr_seen++;
        if (reset_op === 1'b1 && prev_rop !== 1'b1) runs++;
        prev_rop = reset_op;
        if (ch_ready[0] === 1'b1 || ch_ready[1] === 1'b1) rdy_seen++;
        if (busy === 1'b1 && reset_op === 1'b0) run_seen++;
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_all(input logic v, input logic r);
        for (int c = 0; c < 2; c++) begin
            ch_valid[c] = v;
            up_rdy[c]   = r;
            dn_rdy[c]   = r;
            ch_data[c]  = {$urandom, $urandom};
        end
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int g = 0;
        while (m_phase != P_DONE && g < budget) begin
            ch_data[0] = {$urandom, $urandom};
            ch_data[1] = {$urandom, $urandom};
            step();
            g++;
        end
        chk({tag, "_reached_done"}, 64'(m_phase == P_DONE), 64'(1));
    endtask

    initial begin
        logic [31:0] cnt_tmp;
        int held;
        int dn_seen;
        int g;
        logic left_idle;

        reset = 1'b1; start = 1'b0; abort = 1'b0; n_samples = '0; prev_rop = 1'b0;
        set_all(1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_outputs();
        chk("rst_count0", 64'(count0), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        step();

        // 1: N=4, everything ready, valid every cycle
        n_samples = 32'd4; set_all(1'b1, 1'b1); start = 1'b1; clr_seen = 0;
        run_to_done("t1", 60);
        chk("t1_clr_cycles", 64'(clr_seen), 64'(4));
        chk("t1_done", 64'(done), 64'(1));
        chk("t1_count0", 64'(count0), 64'(4));
        chk("t1_count1", 64'(count1), 64'(4));
        start = 1'b0; step(); step();

        // 2: up FIFO of ch0 stalled for 5 cycles while down takes its word at once
        n_samples = 32'd1; set_all(1'b1, 1'b1); start = 1'b1;
        up_rdy[0] = 1'b0; held = 0; dn_seen = 0; g = 0;
        while (m_phase != P_DONE && g < 60) begin
            ch_data[0] = 64'hAAAA_BBBB_CCCC_DDDD;
            up_rdy[0]  = (held >= 5);
            #1;
            if (up_valid[0] === 1'b1 && up_data[0] === 32'hAAAABBBB && !up_rdy[0]) held++;
            if (dn_valid[0] === 1'b1 && dn_data[0] === 32'hCCCCDDDD) dn_seen++;
            step();
            g++;
        end
        chk("t2_reached_done", 64'(m_phase == P_DONE), 64'(1));
        chk("t2_up_held", 64'(held), 64'(5));
        chk("t2_dn_once", 64'(dn_seen), 64'(1));
        start = 1'b0; step(); step();

        // 3: N=0 completes with no result accepted
        n_samples = 32'd0; set_all(1'b1, 1'b1); start = 1'b1;
        rdy_seen = 0; run_seen = 0; clr_seen = 0;
        run_to_done("t3", 40);
        chk("t3_ready_seen", 64'(rdy_seen), 64'(0));
        chk("t3_run_cycles", 64'(run_seen), 64'(1));
        chk("t3_clr_cycles", 64'(clr_seen), 64'(4));
        chk("t3_count0", 64'(count0), 64'(0));
        start = 1'b0; step(); step();

        // 4: abort in RUN with an up word pending and count0=2
        n_samples = 32'd5; set_all(1'b1, 1'b1); ch_valid[1] = 1'b0; start = 1'b1; g = 0;
        while (m_cnt[0] < 2 && g < 40) begin
            ch_data[0] = {$urandom, $urandom};
            step();
            g++;
        end
        up_rdy[0] = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("t4_busy", 64'(busy), 64'(0));
        chk("t4_count0", 64'(count0), 64'(2));
        chk("t4_up0_valid", 64'(up_valid[0]), 64'(0));
        chk("t4_dn0_valid", 64'(dn_valid[0]), 64'(0));
        start = 1'b0; step(); step();

        // 5: start held through DONE never retriggers; exactly two runs
        n_samples = 32'd1; set_all(1'b1, 1'b1); start = 1'b1; runs = 0;
        run_to_done("t5a", 40);
        repeat (5) step();
        chk("t5_still_done", 64'(done), 64'(1));
        start = 1'b0; step(); step();
        start = 1'b1;
        run_to_done("t5b", 40);
        start = 1'b0; step(); step();
        chk("t5_runs", 64'(runs), 64'(2));

        // 6: randomized runs with random back-pressure, valids and occasional abort
        for (int r = 0; r < 10; r++) begin
            n_samples = $urandom_range(0, 6);
            start = 1'b1; left_idle = 1'b0; g = 0;
            while (g < 400) begin
                for (int c = 0; c < 2; c++) begin
                    ch_valid[c] = ($urandom_range(0, 99) < 70);
                    up_rdy[c]   = ($urandom_range(0, 99) < 60);
                    dn_rdy[c]   = ($urandom_range(0, 99) < 60);
                    ch_data[c]  = {$urandom, $urandom};
                end
                abort = (r % 2 == 1) && ($urandom_range(0, 99) < 3);
                step();
                g++;
                if (m_phase != P_IDLE) left_idle = 1'b1;
                if (m_phase == P_DONE || (left_idle && m_phase == P_IDLE)) break;
            end
            chk($sformatf("t6_run%0d_finished", r), 64'(g < 400), 64'(1));
            abort = 1'b0; start = 1'b0; step(); step();
        end

        // 7: asynchronous reset mid-run clears everything without a clock edge
        n_samples = 32'd6; set_all(1'b1, 1'b1); start = 1'b1; g = 0;
        while (m_cnt[0] < 3 && g < 40) begin
            step();
            g++;
        end
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        cnt_tmp = count0 | count1;
        chk("t7_busy", 64'(busy), 64'(0));
        chk("t7_reset_op", 64'(reset_op), 64'(0));
        chk("t7_counts", 64'(cnt_tmp), 64'(0));
        chk("t7_up0_valid", 64'(up_valid[0]), 64'(0));
        chk("t7_dn1_valid", 64'(dn_valid[1]), 64'(0));
        chk("t7_ch0_ready", 64'(ch_ready[0]), 64'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
